// File: rtl/cipher_mmio_ctrl.sv
// Memory-mapped control front-end for a block-cipher core: PT/KEY/CT banks,
// CSR/STATUS registers and an IDLE/BUSY sequencer with hang timeout.
module cipher_mmio_ctrl #(
  parameter int BLOCK_W     = 128,
  parameter int KEY_W       = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [3:0]         we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               irq_o,
  output logic               core_start_o,
  output logic [BLOCK_W-1:0] core_pt_o,
  output logic [KEY_W-1:0]   core_key_o,
  input  logic               core_valid_i,
  input  logic [BLOCK_W-1:0] core_ct_i
);

  localparam int PT_N  = BLOCK_W / 32;
  localparam int KEY_N = KEY_W / 32;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0] PT_CNT  = 4'(PT_N);
  localparam logic [3:0] KEY_CNT = 4'(KEY_N);
  localparam logic [3:0] PT_LAST = 4'(PT_N - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic               auto_q, auto_d;
  logic               irqEn_q, irqEn_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;

  logic       wrAcc, rdAcc, aligned;
  logic [2:0] region;
  logic [3:0] widx;
  logic       ptSel, keySel, ctSel, csrSel, statSel, ptLastSel, launchReq;
  logic       errSet;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                             input logic [31:0] newW,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldW;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = newW[8*b +: 8];
    end
    return res;
  endfunction

  assign wrAcc     = en_i && (we_i != 4'b0000);
  assign rdAcc     = en_i && (we_i == 4'b0000);
  assign aligned   = (addr_i[1:0] == 2'b00);
  assign region    = addr_i[7:5];
  assign widx      = {1'b0, addr_i[4:2]};
  assign ptSel     = aligned && (region == 3'd0) && (widx < PT_CNT);
  assign keySel    = aligned && (region == 3'd1) && (widx < KEY_CNT);
  assign ctSel     = aligned && (region == 3'd2) && (widx < PT_CNT);
  assign csrSel    = aligned && (addr_i[7:2] == 6'h18);
  assign statSel   = aligned && (addr_i[7:2] == 6'h19);
  assign ptLastSel = aligned && (region == 3'd0) && (widx == PT_LAST);
  // A launch is either an explicit START write or, in AUTO mode, filling the last PT word.
  assign launchReq = wrAcc && ((csrSel && we_i[0] && data_i[0]) || (auto_q && ptLastSel));

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
    auto_d  = auto_q;
    irqEn_d = irqEn_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    rdata_d = '0;
    errSet  = 1'b0;

    if (wrAcc && ptSel) begin
      if (state_q == BUSY) errSet = 1'b1;
      else begin
        for (int k = 0; k < PT_N; k++) begin
          if (widx == 4'(k)) pt_d[32*k +: 32] = mergeBytes(pt_q[32*k +: 32], data_i, we_i);
        end
      end
    end
    if (wrAcc && keySel) begin
      if (state_q == BUSY) errSet = 1'b1;
      else begin
        for (int k = 0; k < KEY_N; k++) begin
          if (widx == 4'(k)) key_d[32*k +: 32] = mergeBytes(key_q[32*k +: 32], data_i, we_i);
        end
      end
    end
    if (wrAcc && csrSel && we_i[0]) begin
      auto_d  = data_i[1];
      irqEn_d = data_i[2];
    end
    if (wrAcc && statSel && we_i[0]) begin
      if (data_i[1]) done_d = 1'b0;
      if (data_i[2]) err_d  = 1'b0;
      if (data_i[3]) tmo_d  = 1'b0;
    end

    // Status sets below come after the W1C clears so a simultaneous set wins.
    unique case (state_q)
      IDLE: begin
        if (launchReq) begin
          state_d = BUSY;
          start_d = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      BUSY: begin
        if (launchReq) errSet = 1'b1;
        if (core_valid_i) begin
          ct_d    = core_ct_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          errSet  = 1'b1;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (errSet) err_d = 1'b1;

    if (rdAcc) begin
      for (int k = 0; k < PT_N; k++) begin
        if (ptSel && widx == 4'(k)) rdata_d = pt_q[32*k +: 32];
        if (ctSel && widx == 4'(k)) rdata_d = ct_q[32*k +: 32];
      end
      for (int k = 0; k < KEY_N; k++) begin
        if (keySel && widx == 4'(k)) rdata_d = key_q[32*k +: 32];
      end
      if (csrSel)  rdata_d = {29'b0, irqEn_q, auto_q, 1'b0};
      if (statSel) rdata_d = {28'b0, tmo_q, err_q, done_q, (state_q == BUSY)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      auto_q  <= 1'b0;
      irqEn_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      auto_q  <= auto_d;
      irqEn_q <= irqEn_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_o       = rdata_q;
  assign irq_o        = irqEn_q & (done_q | err_q);
  assign core_start_o = start_q;
  assign core_pt_o    = pt_q;
  assign core_key_o   = key_q;

endmodule
